// File: rtl/adder_arbiter.sv
`default_nettype none
// ============================================================================
// adder_arbiter -- round-robin sharing of one registered adder by two requesters
// Rev 1.0
// ============================================================================
module adder_arbiter #(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             req1_ready,
   output logic             rsp_valid,
   output logic [WIDTH-1:0] rsp_sum,
   output logic             rsp_carry,
   output logic             rsp_id,
   input  logic             rsp_ready,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             last_gnt;   // 1 => requester 1 was granted most recently
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             op_id;
   logic             gnt0;
   logic             gnt1;
   logic [WIDTH:0]   sum_full;

   assign sum_full   = {1'b0, op_a} + {1'b0, op_b};
   assign req0_ready = gnt0;
   assign req1_ready = gnt1;
   assign busy       = (state != IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Grants are gated by rst so the ready outputs drop with reset, not an edge.
   always_comb begin
      state_nxt = state;
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      case (state)
         IDLE: begin
            if (rst) begin
               if (req0_valid && req1_valid) begin
                  gnt0 = last_gnt;
                  gnt1 = ~last_gnt;
               end else begin
                  gnt0 = req0_valid;
                  gnt1 = req1_valid;
               end
            end
            if (gnt0 || gnt1) state_nxt = CALC;
         end
         CALC:    state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_gnt  <= 1'b1;
         op_a      <= '0;
         op_b      <= '0;
         op_id     <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_sum   <= '0;
         rsp_carry <= 1'b0;
         rsp_id    <= 1'b0;
      end else begin
         if (gnt0 || gnt1) begin
            op_a     <= gnt1 ? req1_a : req0_a;
            op_b     <= gnt1 ? req1_b : req0_b;
            op_id    <= gnt1;
            last_gnt <= gnt1;
         end
         if (state == CALC) begin
            {rsp_carry, rsp_sum} <= sum_full;
            rsp_id               <= op_id;
            rsp_valid            <= 1'b1;
         end else if (state == RESP && rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_adder_arbiter.sv
`default_nettype none
// ============================================================================
// tb_adder_arbiter -- directed scenarios plus randomized run against a
// transaction-level model. Rev 1.0
// ============================================================================
module tb_adder_arbiter;

   localparam int W   = 2;
   localparam int MOD = 1 << W;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         req0_valid = 1'b0;
   logic [W-1:0] req0_a = '0;
   logic [W-1:0] req0_b = '0;
   logic         req0_ready;
   logic         req1_valid = 1'b0;
   logic [W-1:0] req1_a = '0;
   logic [W-1:0] req1_b = '0;
   logic         req1_ready;
   logic         rsp_valid;
   logic [W-1:0] rsp_sum;
   logic         rsp_carry;
   logic         rsp_id;
   logic         rsp_ready = 1'b0;
   logic         busy;

   int vectors    = 0;
   int miscompares = 0;

   adder_arbiter #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
      .rsp_valid(rsp_valid), .rsp_sum(rsp_sum), .rsp_carry(rsp_carry), .rsp_id(rsp_id),
      .rsp_ready(rsp_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rsp_ready  = 1'b0;
      rst        = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      logic [7:0] outs;
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         {req0_valid, req1_valid, rsp_ready} = 3'($urandom);
         req0_a = W'($urandom); req0_b = W'($urandom);
         req1_a = W'($urandom); req1_b = W'($urandom);
         #1;
         outs = {req0_ready, req1_ready, rsp_valid, rsp_sum, rsp_carry, rsp_id, busy};
         vectors++;
         if (outs !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_outputs iter %0d: got %b, want all zero", i, outs);
         end
         tick();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      rst = 1'b1;
      #1;
      vectors++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_release: busy=%b rsp_valid=%b, want 0 0", busy, rsp_valid);
      end
      tick();
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_idle_hold: busy=%b, want 0", busy);
      end
   endtask

   task automatic test_single();
      apply_reset();
      req0_valid = 1'b1; req0_a = 2'd3; req0_b = 2'd2; rsp_ready = 1'b1;
      #1;
      vectors++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL single_ready: r0=%b r1=%b, want 1 0", req0_ready, req1_ready);
      end
      tick();
      req0_valid = 1'b0;
      vectors++;
      if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL single_calc: busy=%b rsp_valid=%b, want 1 0", busy, rsp_valid);
      end
      tick();
      vectors++;
      if ({rsp_valid, rsp_sum, rsp_carry, rsp_id} !== {1'b1, 2'd1, 1'b1, 1'b0}) begin
         miscompares++;
         $display("FAIL single_rsp: v=%b sum=%0d c=%b id=%b, want 1 1 1 0",
                  rsp_valid, rsp_sum, rsp_carry, rsp_id);
      end
      tick();
      vectors++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL single_idle: busy=%b rsp_valid=%b, want 0 0", busy, rsp_valid);
      end
   endtask

   task automatic test_round_robin();
      int total;
      apply_reset();
      req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         req0_a = W'($urandom); req0_b = W'($urandom);
         req1_a = W'($urandom); req1_b = W'($urandom);
         total = (k % 2 == 0) ? int'(req0_a) + int'(req0_b) : int'(req1_a) + int'(req1_b);
         #1;
         vectors++;
         if ({req0_ready, req1_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
            miscompares++;
            $display("FAIL rr_grant op %0d: r0=%b r1=%b, want id %0d only",
                     k, req0_ready, req1_ready, k % 2);
         end
         tick();
         vectors++;
         if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rr_ready_calc op %0d: r0=%b r1=%b, want 0 0", k, req0_ready, req1_ready);
         end
         tick();
         vectors++;
         if (rsp_valid !== 1'b1 || rsp_id !== 1'(k % 2) || int'(rsp_sum) != total % MOD ||
             rsp_carry !== 1'(total >= MOD)) begin
            miscompares++;
            $display("FAIL rr_rsp op %0d: v=%b id=%b sum=%0d c=%b, want 1 %0d %0d %0d",
                     k, rsp_valid, rsp_id, rsp_sum, rsp_carry, k % 2, total % MOD, total >= MOD);
         end
         vectors++;
         if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rr_ready_resp op %0d: r0=%b r1=%b, want 0 0", k, req0_ready, req1_ready);
         end
         tick();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
   endtask

   task automatic test_backpressure();
      int total;
      logic [W+1:0] held;
      apply_reset();
      req0_valid = 1'b1; req0_a = W'($urandom); req0_b = W'($urandom);
      total = int'(req0_a) + int'(req0_b);
      held = {1'b1, W'(total % MOD), 1'(total >= MOD)};
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_a = 2'd2; req1_b = 2'd1;
      tick();
      for (int i = 0; i < 5; i++) begin
         vectors++;
         if ({rsp_valid, rsp_sum, rsp_carry} !== held || rsp_id !== 1'b0 ||
             req1_ready !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_hold cycle %0d: vsc=%b id=%b r1=%b busy=%b, want %b 0 0 1",
                     i, {rsp_valid, rsp_sum, rsp_carry}, rsp_id, req1_ready, busy, held);
         end
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      vectors++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0 || req1_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL bp_release: busy=%b v=%b r1=%b, want 0 0 1", busy, rsp_valid, req1_ready);
      end
      tick();
      req1_valid = 1'b0;
      tick();
      vectors++;
      if ({rsp_valid, rsp_sum, rsp_carry, rsp_id} !== {1'b1, 2'd3, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL bp_req1: v=%b sum=%0d c=%b id=%b, want 1 3 0 1",
                  rsp_valid, rsp_sum, rsp_carry, rsp_id);
      end
      tick();
   endtask

   task automatic test_reset_in_calc();
      logic [7:0] outs;
      apply_reset();
      req0_valid = 1'b1; req0_a = 2'd3; req0_b = 2'd3; rsp_ready = 1'b1;
      tick();
      req0_valid = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      outs = {req0_ready, req1_ready, rsp_valid, rsp_sum, rsp_carry, rsp_id, busy};
      vectors++;
      if (outs !== 8'd0) begin
         miscompares++;
         $display("FAIL rst_calc_async: got %b, want all zero", outs);
      end
      tick();
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         vectors++;
         if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_calc_no_rsp cycle %0d: v=%b busy=%b, want 0 0", i, rsp_valid, busy);
         end
      end
      req0_valid = 1'b1; req1_valid = 1'b1; req0_a = 2'd1; req0_b = 2'd1;
      #1;
      vectors++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_calc_first_grant: r0=%b r1=%b, want 1 0", req0_ready, req1_ready);
      end
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick();
      vectors++;
      if ({rsp_valid, rsp_sum, rsp_carry, rsp_id} !== {1'b1, 2'd2, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL rst_calc_rsp: v=%b sum=%0d c=%b id=%b, want 1 2 0 0",
                  rsp_valid, rsp_sum, rsp_carry, rsp_id);
      end
      tick();
   endtask

   task automatic test_req1_overflow();
      apply_reset();
      req1_valid = 1'b1; req1_a = 2'd3; req1_b = 2'd3; rsp_ready = 1'b1;
      #1;
      vectors++;
      if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL ovf_ready: r0=%b r1=%b, want 0 1", req0_ready, req1_ready);
      end
      tick();
      req1_valid = 1'b0;
      tick();
      vectors++;
      if ({rsp_valid, rsp_sum, rsp_carry, rsp_id} !== {1'b1, 2'd2, 1'b1, 1'b1}) begin
         miscompares++;
         $display("FAIL ovf_rsp: v=%b sum=%0d c=%b id=%b, want 1 2 1 1",
                  rsp_valid, rsp_sum, rsp_carry, rsp_id);
      end
      tick();
   endtask

   // Model: an adder slot and a response slot; a request is taken only when
   // both are empty, and a response takes one cycle to move out of the adder.
   task automatic test_random();
      bit in_adder = 0, have_rsp = 0, last_was1 = 1;
      int adder_total = 0, rsp_total = 0;
      bit adder_id = 0, rsp_owner = 0;
      bit exp0, exp1;
      apply_reset();
      for (int cyc = 0; cyc < 400; cyc++) begin
         req0_valid = 1'($urandom_range(0, 1));
         req1_valid = 1'($urandom_range(0, 1));
         req0_a = W'($urandom); req0_b = W'($urandom);
         req1_a = W'($urandom); req1_b = W'($urandom);
         rsp_ready = ($urandom_range(0, 3) != 0);
         exp0 = 0; exp1 = 0;
         if (!in_adder && !have_rsp) begin
            if (req0_valid && req1_valid) begin
               exp0 = last_was1; exp1 = !last_was1;
            end else begin
               exp0 = req0_valid; exp1 = req1_valid;
            end
         end
         #1;
         vectors++;
         if (req0_ready !== exp0 || req1_ready !== exp1 || busy !== (in_adder || have_rsp) ||
             rsp_valid !== have_rsp) begin
            miscompares++;
            $display("FAIL rand_ctrl cyc %0d: r0=%b r1=%b busy=%b v=%b, want %b %b %b %b",
                     cyc, req0_ready, req1_ready, busy, rsp_valid,
                     exp0, exp1, in_adder || have_rsp, have_rsp);
         end
         if (have_rsp) begin
            vectors++;
            if (int'(rsp_sum) != rsp_total % MOD || rsp_carry !== 1'(rsp_total >= MOD) ||
                rsp_id !== rsp_owner) begin
               miscompares++;
               $display("FAIL rand_data cyc %0d: sum=%0d c=%b id=%b, want %0d %0d %b",
                        cyc, rsp_sum, rsp_carry, rsp_id, rsp_total % MOD,
                        rsp_total >= MOD, rsp_owner);
            end
         end
         if (have_rsp) begin
            if (rsp_ready) have_rsp = 0;
         end else if (in_adder) begin
            in_adder = 0; have_rsp = 1;
            rsp_total = adder_total; rsp_owner = adder_id;
         end else if (exp0 || exp1) begin
            in_adder = 1; adder_id = exp1; last_was1 = exp1;
            adder_total = exp1 ? int'(req1_a) + int'(req1_b) : int'(req0_a) + int'(req0_b);
         end
         tick();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_reset_in_calc();
      test_req1_overflow();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter: WIDTH, 2, operand and sum width in bits.
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  reset, asynchronous, active-low (rst=0 resets).
REQ-004 Port: req0_valid  in  1  requester 0 has an operation pending.
REQ-005 Port: req0_a, req0_b  in  WIDTH each  requester 0 operands.
REQ-006 Port: req0_ready  out  1  requester 0 operation accepted this cycle.
REQ-007 Port: req1_valid, req1_a, req1_b, req1_ready  same as requester 0, for requester 1.
REQ-008 Port: rsp_valid  out  1  result available.
REQ-009 Port: rsp_sum  out  WIDTH  (a+b) mod 2^WIDTH.
REQ-010 Port: rsp_carry  out  1  carry-out of a+b.
REQ-011 Port: rsp_id  out  1  requester index owning the result.
REQ-012 Port: rsp_ready  in  1  consumer accepts result.
REQ-013 Port: busy  out  1  high whenever state is not IDLE.

Function
REQ-014 The block SHALL time-share one registered WIDTH-bit adder between two requesters using a three-state FSM: IDLE, CALC, RESP.
REQ-015 IDLE: if neither valid, stay IDLE; if exactly one valid, grant it; if both valid, grant the requester not granted last (round-robin).
REQ-016 reqN_ready SHALL be high only in IDLE and only for the granted requester; it is combinational from state, valids and the round-robin pointer and never depends on rsp_ready.
REQ-017 Acceptance = reqN_valid & reqN_ready at a rising edge: operands and grant index latched, pointer set to the granted index, state -> CALC.
REQ-018 CALC lasts exactly one cycle: at its closing edge {rsp_carry, rsp_sum} <= a + b at WIDTH+1 bits, rsp_id <= grant index, rsp_valid <= 1, state -> RESP.
REQ-019 Latency: operation accepted at edge N SHALL show rsp_valid=1 after edge N+1.
REQ-020 RESP: rsp_valid, rsp_sum, rsp_carry and rsp_id SHALL hold stable while rsp_ready=0.
REQ-021 RESP with rsp_ready=1 at an edge: rsp_valid <= 0, state -> IDLE; no new acceptance in that same cycle. Peak throughput is one operation per 3 cycles.
REQ-022 The round-robin pointer SHALL change only on acceptance; valids asserted outside IDLE are ignored and not queued.
REQ-023 A requester deasserting valid before acceptance SHALL lose the request with no state change.
REQ-024 Overflow wraps: sum truncated to WIDTH bits, carry reported separately; no saturation.
REQ-025 busy = (state != IDLE).

Reset
REQ-026 While rst=0, the block SHALL immediately, without a clock edge, force state=IDLE, rsp_valid=0, rsp_sum=0, rsp_carry=0, rsp_id=0, busy=0, req0_ready=req1_ready=0, and set the pointer to "last granted = 1" so requester 0 wins the first contention.
REQ-027 Reset asserted in CALC or RESP SHALL discard the in-flight operation and produce no response.
REQ-028 After rst returns to 1, the first acceptance SHALL be possible at the first rising edge.

Verification
REQ-029 Hold rst=0 with random inputs -> all outputs 0; release rst -> IDLE, busy=0.
REQ-030 req0 only, a=3, b=2, rsp_ready=1 -> req0_ready=1 in IDLE; one edge after acceptance rsp_valid=1, rsp_sum=1, rsp_carry=1, rsp_id=0; IDLE again next edge.
REQ-031 Both valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,0,1, one result every 3 cycles; the non-granted ready never high.
REQ-032 rsp_ready=0 for 5 cycles in RESP with req1 valid -> outputs held bit-stable, req1_ready=0, busy=1; rsp_ready=1 -> IDLE, then req1 accepted.
REQ-033 rst pulsed low during CALC (operands a=3, b=3) -> outputs 0 asynchronously, no response; then both valid -> requester 0 granted first.
REQ-034 req1 a=3, b=3 -> rsp_sum=2, rsp_carry=1, rsp_id=1.
